// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the ALU writeback stage and a
// FIFO of long-latency results, and tracks in-flight long-latency destinations.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  output logic        alu_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_addr,
  input  logic [4:0]  qaddr1,
  input  logic [4:0]  qaddr2,
  input  logic [4:0]  qaddr_d,
  output logic        hazard1,
  output logic        hazard2,
  output logic        hazard_d,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pend_q, pend_d;

  logic full, empty, alu_req, pop, push_store;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign alu_req    = alu_we && (alu_waddr != 5'd0);
  assign head_addr  = addr_mem[rd_ptr_q];
  assign head_data  = data_mem[rd_ptr_q];
  // A full FIFO outranks the ALU so a stalled pipeline always drains.
  assign pop        = full || (!alu_req && !empty);
  assign push_store = lu_valid && !full && (lu_waddr != 5'd0);

  assign lu_ready  = !full;
  assign alu_stall = full;
  assign hazard1   = pend_q[qaddr1];
  assign hazard2   = pend_q[qaddr2];
  assign hazard_d  = pend_q[qaddr_d];

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end else if (alu_req) begin
      rf_we    = 1'b1;
      rf_waddr = alu_waddr;
      rf_wdata = alu_wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_store) - CW'(pop);
    pend_d   = pend_q;
    if (push_store) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      pend_d[head_addr] = 1'b0;
    end
    // Issue is applied after the pop clear so a same-cycle set wins.
    if (lu_issue) pend_d[lu_issue_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_store) begin
      addr_mem[wr_ptr_q] <= lu_waddr;
      data_mem[wr_ptr_q] <= lu_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        alu_stall;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic [4:0]  qaddr1, qaddr2, qaddr_d;
  logic        hazard1, hazard2, hazard_d;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t      mq[$];
  bit [31:0] mpend;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_stall(alu_stall),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
    .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
    .qaddr1(qaddr1), .qaddr2(qaddr2), .qaddr_d(qaddr_d),
    .hazard1(hazard1), .hazard2(hazard2), .hazard_d(hazard_d),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; alu_we = 1'b0; alu_waddr = 5'd0; alu_wdata = 32'd0;
    lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0;
    lu_issue = 1'b0; lu_issue_addr = 5'd0;
    qaddr1 = 5'd0; qaddr2 = 5'd0; qaddr_d = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    alu_we = 1'b1; alu_waddr = 5'd6; alu_wdata = 32'h1234_5678;
    qaddr1 = 5'd1; qaddr2 = 5'd17; qaddr_d = 5'd31;
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", lu_ready); end
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", alu_stall); end
    checks++; if ({hazard1, hazard2, hazard_d} !== 3'b000) begin errors++; $display("FAIL reset_hazards got %b exp 000", {hazard1, hazard2, hazard_d}); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_alu_pass got we=%b a=%0d d=%h exp we=1 a=6 d=12345678", rf_we, rf_waddr, rf_wdata); end
    alu_waddr = 5'd0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_addr0 got we=%b exp 0", rf_we); end
    idle();
  endtask

  task automatic test_single_push();
    lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL push_same_cycle got we=%b exp 0", rf_we); end
    tick();
    idle();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_push got we=%b a=%0d d=%h exp we=1 a=5 d=deadbeef", rf_we, rf_waddr, rf_wdata); end
    tick();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_push_drained got we=%b exp 0", rf_we); end
  endtask

  task automatic test_fill_stall();
    alu_we = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h33;
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
    #1;
    checks++; if (rf_waddr !== 5'd3 || rf_we !== 1'b1) begin errors++; $display("FAIL fill_c1 got a=%0d exp 3", rf_waddr); end
    tick();
    lu_waddr = 5'd8; lu_wdata = 32'h88;
    #1;
    checks++; if (rf_waddr !== 5'd3 || lu_ready !== 1'b1 || alu_stall !== 1'b0) begin
      errors++; $display("FAIL fill_c2 got a=%0d rdy=%b stall=%b exp 3 1 0", rf_waddr, lu_ready, alu_stall); end
    tick();
    lu_valid = 1'b0;
    #1;
    checks++; if (alu_stall !== 1'b1 || lu_ready !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin
      errors++; $display("FAIL full_head got stall=%b rdy=%b a=%0d d=%h exp 1 0 7 77", alu_stall, lu_ready, rf_waddr, rf_wdata); end
    tick();
    #1;
    checks++; if (alu_stall !== 1'b0 || rf_waddr !== 5'd3) begin
      errors++; $display("FAIL stall_drop got stall=%b a=%0d exp 0 3", alu_stall, rf_waddr); end
    alu_we = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h88) begin
      errors++; $display("FAIL drain_second got we=%b a=%0d d=%h exp 1 8 88", rf_we, rf_waddr, rf_wdata); end
    tick();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL fill_drained got we=%b exp 0", rf_we); end
    idle();
  endtask

  task automatic test_hazard();
    lu_issue = 1'b1; lu_issue_addr = 5'd9;
    tick();
    lu_issue = 1'b0; qaddr1 = 5'd9;
    #1;
    checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL hazard_set got %b exp 1", hazard1); end
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    tick();
    lu_valid = 1'b0;
    #1;
    checks++; if (hazard1 !== 1'b1 || rf_waddr !== 5'd9 || rf_we !== 1'b1) begin
      errors++; $display("FAIL hazard_at_pop got hz=%b a=%0d exp 1 9", hazard1, rf_waddr); end
    tick();
    #1;
    checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL hazard_clear got %b exp 0", hazard1); end
    idle();
  endtask

  task automatic test_set_wins();
    lu_issue = 1'b1; lu_issue_addr = 5'd4;
    tick();
    lu_issue = 1'b0;
    lu_valid = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h44;
    tick();
    lu_valid = 1'b0;
    lu_issue = 1'b1; lu_issue_addr = 5'd4; qaddr2 = 5'd4;
    #1;
    checks++; if (rf_waddr !== 5'd4 || rf_we !== 1'b1) begin errors++; $display("FAIL set_wins_pop got a=%0d exp 4", rf_waddr); end
    tick();
    lu_issue = 1'b0;
    #1;
    checks++; if (hazard2 !== 1'b1) begin errors++; $display("FAIL set_wins got hz=%b exp 1", hazard2); end
    lu_valid = 1'b1; lu_waddr = 5'd4;
    tick();
    lu_valid = 1'b0;
    tick();
    #1;
    checks++; if (hazard2 !== 1'b0) begin errors++; $display("FAIL set_wins_clear got hz=%b exp 0", hazard2); end
    idle();
  endtask

  task automatic test_zero_addr();
    lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", lu_ready); end
    tick();
    lu_valid = 1'b0;
    lu_issue = 1'b1; lu_issue_addr = 5'd0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_not_stored got we=%b exp 0", rf_we); end
    tick();
    lu_issue = 1'b0; qaddr_d = 5'd0; qaddr1 = 5'd0;
    #1;
    checks++; if (hazard_d !== 1'b0 || hazard1 !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL zero_issue got hz=%b we=%b exp 0 0", hazard_d, rf_we); end
    idle();
  endtask

  task automatic test_reset_mid();
    lu_issue = 1'b1; lu_issue_addr = 5'd10;
    alu_we = 1'b1; alu_waddr = 5'd2; alu_wdata = 32'h22;
    lu_valid = 1'b1; lu_waddr = 5'd12; lu_wdata = 32'hC;
    tick();
    lu_issue_addr = 5'd11; lu_waddr = 5'd13;
    tick();
    lu_issue = 1'b0; lu_valid = 1'b0;
    #1;
    checks++; if (alu_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_full got stall=%b exp 1", alu_stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0; alu_we = 1'b0;
    qaddr1 = 5'd10; qaddr2 = 5'd11; qaddr_d = 5'd12;
    #1;
    checks++; if (lu_ready !== 1'b1 || alu_stall !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got rdy=%b stall=%b exp 1 0", lu_ready, alu_stall); end
    checks++; if ({hazard1, hazard2, hazard_d} !== 3'b000) begin errors++; $display("FAIL mid_reset_hazards got %b exp 000", {hazard1, hazard2, hazard_d}); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_reset_discard got we=%b exp 0", rf_we); end
    idle();
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    prev = 5'd0;
    for (int k = 1; k <= 3 * DEPTH + 1; k++) begin
      lu_valid = (k <= 3 * DEPTH);
      lu_waddr = 5'(k + 14); lu_wdata = 32'(k * 32'h101);
      #1;
      if (k > 1) begin
        checks++; if (rf_we !== 1'b1 || rf_waddr !== prev || rf_wdata !== 32'((k - 1) * 32'h101)) begin
          errors++; $display("FAIL wrap_%0d got we=%b a=%0d d=%h exp a=%0d", k, rf_we, rf_waddr, rf_wdata, prev); end
      end
      prev = lu_waddr;
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    bit    m_full, m_alu, m_pop;
    bit    e_we;
    bit [4:0]  e_a;
    bit [31:0] e_d;
    ent_t  e;
    idle();
    do_reset();
    mq.delete();
    mpend = '0;
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      alu_we        = ($urandom_range(0, 99) < 45);
      alu_waddr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_wdata     = $urandom;
      lu_valid      = ($urandom_range(0, 99) < 55);
      lu_waddr      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      lu_wdata      = $urandom;
      lu_issue      = ($urandom_range(0, 99) < 40);
      lu_issue_addr = 5'($urandom);
      qaddr1 = 5'($urandom); qaddr2 = 5'($urandom); qaddr_d = 5'($urandom);
      #1;
      m_full = (mq.size() == DEPTH);
      m_alu  = alu_we && (alu_waddr != 0);
      m_pop  = m_full || (!m_alu && mq.size() > 0);
      e_we = m_pop || m_alu; e_a = '0; e_d = '0;
      if (m_pop) begin e_a = mq[0].a; e_d = mq[0].d; end
      else if (m_alu) begin e_a = alu_waddr; e_d = alu_wdata; end
      checks++; if (rf_we !== e_we || rf_waddr !== e_a || rf_wdata !== e_d) begin
        errors++; $display("FAIL rand_rf c=%0d got we=%b a=%0d d=%h exp we=%b a=%0d d=%h", c, rf_we, rf_waddr, rf_wdata, e_we, e_a, e_d); end
      checks++; if (lu_ready !== !m_full || alu_stall !== m_full) begin
        errors++; $display("FAIL rand_flags c=%0d got rdy=%b stall=%b exp full=%b", c, lu_ready, alu_stall, m_full); end
      checks++; if (hazard1 !== mpend[qaddr1] || hazard2 !== mpend[qaddr2] || hazard_d !== mpend[qaddr_d]) begin
        errors++; $display("FAIL rand_hazard c=%0d got %b%b%b exp %b%b%b", c, hazard1, hazard2, hazard_d, mpend[qaddr1], mpend[qaddr2], mpend[qaddr_d]); end
      if (rst) begin
        mq.delete();
        mpend = '0;
      end else begin
        if (m_pop) begin
          e = mq.pop_front();
          mpend[e.a] = 1'b0;
        end
        if (lu_valid && !m_full && lu_waddr != 0) begin
          e.a = lu_waddr; e.d = lu_wdata;
          mq.push_back(e);
        end
        if (lu_issue && lu_issue_addr != 0) mpend[lu_issue_addr] = 1'b1;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_single_push();
    test_fill_stall();
    test_hazard();
    test_set_wins();
    test_zero_addr();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the single register-file write port between two producers.
  - The single-cycle ALU writeback stage.
  - The long-latency unit (load/multiply/divide), which returns results out of pipeline order.
- Buffers long-latency results in a small FIFO.
- Keeps a per-register pending scoreboard, so decode can detect RAW/WAW hazards against in-flight long-latency destinations.
- Sits between the writeback stage and the register file's `we`/`writeaddr`/`writedata` inputs.

## Interface
Parameters:
- `DEPTH`, 2: long-latency result FIFO entries; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_we` in 1: ALU writeback request.
- `alu_waddr` in 5: ALU destination.
- `alu_wdata` in 32: ALU result.
- `alu_stall` out 1: hold ALU writeback; the request is ignored this cycle.
- `lu_valid` in 1: long-latency result valid.
- `lu_waddr` in 5: long-latency destination.
- `lu_wdata` in 32: long-latency result.
- `lu_ready` out 1: FIFO can accept; push occurs when `lu_valid && lu_ready`.
- `lu_issue` in 1: decode issued a long-latency op this cycle.
- `lu_issue_addr` in 5: its destination.
- `qaddr1`, `qaddr2`, `qaddr_d` in 5 each: decode source/destination queries.
- `hazard1`, `hazard2`, `hazard_d` out 1 each: queried register is pending.
- `rf_we` out 1: to register file `we`.
- `rf_waddr` out 5: to `writeaddr`.
- `rf_wdata` out 32: to `writedata`.

## Operation
- State:
  - FIFO storage: `DEPTH` × {5-bit addr, 32-bit data}.
  - Read/write pointers of log2(`DEPTH`) bits; both wrap modulo `DEPTH`.
  - Count of log2(`DEPTH`)+1 bits.
  - 32-bit `pend` vector; bit 0 is hardwired 0.
- `full` = (count == `DEPTH`); `empty` = (count == 0).
- Flags: `lu_ready` = !`full`; `alu_stall` = `full`. Both depend on registered state only.
- Grant, evaluated combinationally each cycle, in priority order:
  1. `full`: FIFO head is granted. `rf_we`=1 with head addr/data; the ALU request is ignored.
  2. `alu_we` && `alu_waddr` != 0: ALU is granted. `rf_we`=1 with ALU addr/data.
  3. !`empty`: FIFO head is granted.
  4. Otherwise `rf_we`=0. `rf_waddr`/`rf_wdata` are don't-care, driven 0.
- Pop: at the rising edge when the head is granted.
- Push: at the rising edge when `lu_valid && lu_ready`.
  - `lu_waddr`==0 is accepted (handshake completes) but not stored; count is unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance. This is only possible when not full.
- Addresses 30/31 pass through unmodified; the register file handles them.
- Scoreboard:
  - Set `pend[lu_issue_addr]` on `lu_issue` (ignored for addr 0).
  - Clear `pend[addr]` when a FIFO entry with that addr is popped.
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never affect `pend`.
- Hazard outputs: `hazardN` = `pend[qaddrN]`, combinational from registered `pend`. Address 0 always returns 0.
- Decode is responsible for stalling on `hazard_d` before issuing an ALU or long-latency op to a pending destination. The block neither checks nor reorders WAW.

## Timing
- ALU writeback latency is 0: its request reaches `rf_*` in the same cycle, so register-file read bypass still applies.
- A long-latency result pushed at edge N:
  - becomes head at cycle N+1;
  - is written at the earliest cycle N+1, if it is the only entry and no ALU request is present.
- `pend` bit cleared at the pop edge: the hazard output drops the next cycle. The register file holds the value from that same edge.
- `alu_stall` asserts the cycle after the FIFO becomes full and stays high while full. A stalled pipeline re-presents the same request; at most `DEPTH` cycles pass until the FIFO is no longer full.
- Reset (`rst` high at an edge):
  - count=0, pointers=0, `pend`=0.
  - Next cycle: `lu_ready`=1, `alu_stall`=0, all hazards 0, `rf_we`=`alu_we`&&(`alu_waddr`!=0).
  - Reset mid-operation discards buffered results and pending bits without writing them.
  - Reset overrides push/pop/issue in the same cycle.

## Test plan
- After reset, `lu_valid`=1, addr 5, data 0xDEADBEEF, no ALU traffic → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; count returns to 0.
- ALU writes addr 3 continuously while the long-latency unit pushes addrs 7, 8:
  - cycles 1-2: ALU is granted and the FIFO fills;
  - next cycle: `alu_stall`=1, `lu_ready`=0, `rf_waddr`=7 (ALU ignored);
  - `alu_stall` drops the cycle after.
- `lu_issue` addr 9 → `hazard1`=1 for `qaddr1`=9 the next cycle; push addr 9 and let it pop → `hazard1`=0 the cycle after the pop.
- Same-cycle pop of addr 4 and `lu_issue` addr 4 → `pend[4]` stays 1.
- Push with `lu_waddr`=0 → handshake completes, count stays 0, `rf_we` stays 0; `lu_issue` addr 0 → `hazard`=0.
- Fill the FIFO and set pending bits, then assert `rst` → the following cycle count=0, all hazards 0, `lu_ready`=1, no `rf_we` from the FIFO; pointer wrap verified over 3×`DEPTH` pushes with in-order addresses.
